fp_add_unit: RTL and testbench
==============================

# fp_add_unit

Multi-cycle IEEE-754 single-precision adder/subtractor in the CPU execute stage. Consumes the two floating-point operands delivered on `rs1_data`/`rs2_data` and produces a rounded FP32 result plus exception flags for write-back. It uses a start/busy/done handshake with a fixed 5-cycle latency. Rounding is round-to-nearest-even. Subnormals are flushed to zero.

## Interface
- `EXP_W`, default 8: exponent width; fixed for FP32, not to be overridden.
- `MAN_W`, default 23: stored mantissa width; fixed for FP32.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only while `busy`=0.
- `op`  in  1: 0 = rs1+rs2, 1 = rs1−rs2; sampled with `start`.
- `rs1_data`  in  32: operand A (FP32).
- `rs2_data`  in  32: operand B (FP32).
- `busy`  out  1: operation in flight (states ALIGN..DONE).
- `done`  out  1: one-cycle pulse; `result`/flags valid.
- `result`  out  32: FP32 result; held until next accepted start.
- `flag_invalid`  out  1: NaN operand or inf−inf.
- `flag_overflow`  out  1: result rounded to ±inf.
- `flag_underflow`  out  1: nonzero result flushed to ±0.

## Operation
- Reset: state=IDLE; `busy`=0, `done`=0, `result`=0, all flags 0.
- FSM sequence: IDLE → ALIGN → ADD → NORM → ROUND → DONE → IDLE. No state stalls, and no early exit for special cases.
- IDLE: if `start`=1, latch operands and `op`, then go to ALIGN. If `op`=1, B sign is inverted at latch time.
- ALIGN:
  - Unpack operands; exp=0 means zero, so the mantissa is discarded (flush-to-zero).
  - Prepend the hidden 1 to nonzero operands.
  - Swap so A has the larger magnitude (compare exp, then mantissa).
  - Right-shift B's 24-bit significand by the exponent difference into a 27-bit {sig,G,R,S} field.
  - Shift ≥ 26 leaves only the sticky bit.
- ADD:
  - Effective add if signs match: 28-bit sum.
  - Otherwise subtract smaller from larger; result sign = sign of A.
- NORM:
  - On carry-out, shift right 1 and increment exp; sticky ORs in the shifted-out bit.
  - Otherwise left-shift by the leading-zero count, computed in one cycle, and decrement exp.
  - Exact zero sum → result +0, except (−0)+(−0) → −0.
- ROUND:
  - RNE: increment if G & (R | S | lsb).
  - Mantissa overflow renormalizes and increments exp.
  - exp ≥ 255 → ±inf (0x7F800000 with sign), `flag_overflow`=1.
  - exp ≤ 0 with a nonzero value → signed zero, `flag_underflow`=1.
- Special cases are decided in ALIGN and override the datapath result at DONE:
  - Any NaN → 0x7FC00000, `flag_invalid`=1.
  - inf + (−inf) after op applied → 0x7FC00000, `flag_invalid`=1.
  - One or both operands inf of the same sign → that inf, no flags.
- DONE: register `result` and flags, pulse `done`, return to IDLE.
- Flags are cleared when a new start is accepted and are otherwise held with `result`.

## Timing
- Number rising edges from E0, the edge that samples `start`=1 in IDLE.
- `busy`=1 from after E0 until after E5.
- `done`=1 exactly between E4 and E5; `result`/flags update at E4.
- Next start can be accepted at E5, giving throughput of one operation per 5 cycles.
- `start` while `busy`=1 is ignored and not queued. Operand changes while busy have no effect.
- `start` held high continuously restarts at every E5, sampling operands present at that edge.
- `reset` asserted at any point, including mid-operation, immediately forces IDLE and clears all outputs. No `done` is produced for the aborted operation.
- `reset` deasserted coincident with a `start` edge: the start is accepted only if `reset` is low at that edge.

## Test plan
- Add, same sign: rs1=0xBE800000 (−0.25), rs2=0xBE700000 (−0.234375), op=0, start at E0 → `done` at E4; result=0xBEF80000; flags 0.
- Subtract, same operands: op=1 → result=0xBC800000 (−0.015625). Exercises the NORM left shift of 4.
- Cancellation and rounding:
  - 0x3F800000 − 0x3F800000 → 0x00000000.
  - 0x3F800000 + 0x33800000 (1 + 2^−24, tie) → 0x3F800000 (RNE to even).
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, `flag_invalid`=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `flag_overflow`=1.
  - 0x00400000 + 0x00000000 → 0x00000000 (flush).
- Handshake:
  - Second `start` pulsed at E2 → ignored; only one `done` pulse, at E4.
  - `start` held high → `done` at E4, E9, E14.
- Reset mid-op: `reset` asserted asynchronously between E2 and E3 → `busy`, `done`, `result`, flags go to 0 immediately; no `done` pulse.
- After reset deasserts, a fresh op completes normally.

Source files
------------

// File: rtl/fp_add_unit.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_unit
// Purpose  : Multi-cycle IEEE-754 single-precision adder/subtractor.
//            Round-to-nearest-even, subnormal inputs and results flushed to
//            zero. Fixed five-cycle start-to-done latency through the
//            sequence IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Ports    : clock, reset (async, active-high)
//            start, op (0 = add, 1 = sub), rs1_data, rs2_data  -- request
//            busy, done, result, flag_invalid/overflow/underflow -- response
// Revision : 1.0  initial release
// ============================================================================
module fp_add_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   rs1_data,
    input  logic [EXP_W+MAN_W:0]   rs2_data,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_underflow
);

    localparam int c_WORD_W = EXP_W + MAN_W + 1;    // 32
    localparam int c_SIG_W  = MAN_W + 1;            // 24, with hidden bit
    localparam int c_FLD_W  = c_SIG_W + 3;          // 27, {sig, G, R, S}
    localparam int c_SUM_W  = c_FLD_W + 1;          // 28, with carry
    localparam int c_PAD_W  = c_FLD_W - 1;          // 26, alignment spill
    localparam int c_T_W    = c_FLD_W + c_PAD_W;    // 53

    localparam logic [EXP_W-1:0]    c_EXP_MAX = '1;
    localparam logic [c_WORD_W-1:0] c_QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // A new request is taken in IDLE and also in DONE, so a held start
    // restarts back-to-back every five cycles.
    logic w_accept;
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_ALIGN;
            S_ALIGN: w_state_next = S_ADD;
            S_ADD:   w_state_next = S_NORM;
            S_NORM:  w_state_next = S_ROUND;
            S_ROUND: w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_ALIGN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Operand latch (B already carries the op-adjusted sign)
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] r_a, r_b;

    // ------------------------------------------------------------------
    // ALIGN: unpack, classify, order by magnitude, align B
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]    w_exp_a, w_exp_b;
    logic [MAN_W-1:0]    w_man_a, w_man_b;
    logic                w_zero_a, w_zero_b;
    logic                w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [c_WORD_W-2:0] w_key_a, w_key_b, w_big_key, w_sml_key;
    logic                w_swap, w_big_sign, w_sml_sign;
    logic [EXP_W-1:0]    w_big_exp, w_sml_exp, w_diff;
    logic [c_SIG_W-1:0]  w_big_sig, w_sml_sig;
    logic [c_T_W-1:0]    w_shift_t;
    logic [c_FLD_W-1:0]  w_field_b;
    logic                w_spec, w_spec_inv;
    logic [c_WORD_W-1:0] w_spec_val;

    assign w_exp_a  = r_a[c_WORD_W-2:MAN_W];
    assign w_exp_b  = r_b[c_WORD_W-2:MAN_W];
    assign w_man_a  = r_a[MAN_W-1:0];
    assign w_man_b  = r_b[MAN_W-1:0];
    assign w_zero_a = (w_exp_a == '0);
    assign w_zero_b = (w_exp_b == '0);
    assign w_nan_a  = (w_exp_a == c_EXP_MAX) && (w_man_a != '0);
    assign w_nan_b  = (w_exp_b == c_EXP_MAX) && (w_man_b != '0);
    assign w_inf_a  = (w_exp_a == c_EXP_MAX) && (w_man_a == '0);
    assign w_inf_b  = (w_exp_b == c_EXP_MAX) && (w_man_b == '0);

    // Flushed operands compare as zero magnitude.
    assign w_key_a    = w_zero_a ? '0 : r_a[c_WORD_W-2:0];
    assign w_key_b    = w_zero_b ? '0 : r_b[c_WORD_W-2:0];
    assign w_swap     = (w_key_b > w_key_a);
    assign w_big_key  = w_swap ? w_key_b : w_key_a;
    assign w_sml_key  = w_swap ? w_key_a : w_key_b;
    assign w_big_sign = w_swap ? r_b[c_WORD_W-1] : r_a[c_WORD_W-1];
    assign w_sml_sign = w_swap ? r_a[c_WORD_W-1] : r_b[c_WORD_W-1];
    assign w_big_exp  = w_big_key[c_WORD_W-2:MAN_W];
    assign w_sml_exp  = w_sml_key[c_WORD_W-2:MAN_W];
    assign w_big_sig  = {(w_big_exp != '0), w_big_key[MAN_W-1:0]};
    assign w_sml_sig  = {(w_sml_exp != '0), w_sml_key[MAN_W-1:0]};
    assign w_diff     = w_big_exp - w_sml_exp;

    // Padding below the field keeps every shifted-out bit for the sticky OR.
    assign w_shift_t = {w_sml_sig, 3'b000, {c_PAD_W{1'b0}}} >> w_diff;

    always_comb begin
        if (w_diff >= EXP_W'(c_PAD_W)) begin
            w_field_b = {{(c_FLD_W-1){1'b0}}, (w_sml_sig != '0)};
        end else begin
            w_field_b = {w_shift_t[c_T_W-1:c_PAD_W+1],
                         w_shift_t[c_PAD_W] | (|w_shift_t[c_PAD_W-1:0])};
        end
    end

    always_comb begin
        w_spec     = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
        w_spec_inv = 1'b0;
        w_spec_val = c_QNAN;
        if (w_nan_a || w_nan_b ||
            (w_inf_a && w_inf_b && (r_a[c_WORD_W-1] != r_b[c_WORD_W-1]))) begin
            w_spec_inv = 1'b1;
        end else if (w_inf_a) begin
            w_spec_val = {r_a[c_WORD_W-1], c_EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            w_spec_val = {r_b[c_WORD_W-1], c_EXP_MAX, {MAN_W{1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Pipeline-of-states registers
    // ------------------------------------------------------------------
    logic                r_sign, r_eff_sub, r_neg_zero, r_is_zero;
    logic signed [9:0]   r_exp;
    logic [c_FLD_W-1:0]  r_sig_a, r_sig_b, r_mant;
    logic [c_SUM_W-1:0]  r_sum;
    logic                r_spec, r_spec_inv;
    logic [c_WORD_W-1:0] r_spec_val;

    // ------------------------------------------------------------------
    // NORM: single-cycle leading-zero count over the 27-bit field
    // ------------------------------------------------------------------
    logic [4:0] w_lzc;
    always_comb begin
        w_lzc = 5'(c_FLD_W);
        for (int i = 0; i < c_FLD_W; i++) begin
            if (r_sum[i]) w_lzc = 5'(c_FLD_W - 1 - i);
        end
    end

    // ------------------------------------------------------------------
    // ROUND: RNE on {sig, G, R, S}, then range checks
    // ------------------------------------------------------------------
    logic                w_inc;
    logic [c_SIG_W:0]    w_rsig;
    logic signed [9:0]   w_rexp;
    logic [MAN_W-1:0]    w_frac;
    logic [c_WORD_W-1:0] w_final;
    logic                w_ovf, w_unf;

    assign w_inc  = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    assign w_rsig = {1'b0, r_mant[c_FLD_W-1:3]} + {{c_SIG_W{1'b0}}, w_inc};
    assign w_rexp = r_exp + $signed({9'd0, w_rsig[c_SIG_W]});
    assign w_frac = w_rsig[c_SIG_W] ? w_rsig[c_SIG_W-1:1] : w_rsig[MAN_W-1:0];

    always_comb begin
        w_final = {r_sign, w_rexp[EXP_W-1:0], w_frac};
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        if (r_is_zero) begin
            w_final = {r_neg_zero, {(c_WORD_W-1){1'b0}}};
        end else if (w_rexp >= 10'sd255) begin
            w_final = {r_sign, c_EXP_MAX, {MAN_W{1'b0}}};
            w_ovf   = 1'b1;
        end else if (w_rexp <= 10'sd0) begin
            w_final = {r_sign, {(c_WORD_W-1){1'b0}}};
            w_unf   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a            <= '0;
            r_b            <= '0;
            r_sign         <= 1'b0;
            r_eff_sub      <= 1'b0;
            r_neg_zero     <= 1'b0;
            r_is_zero      <= 1'b0;
            r_exp          <= '0;
            r_sig_a        <= '0;
            r_sig_b        <= '0;
            r_mant         <= '0;
            r_sum          <= '0;
            r_spec         <= 1'b0;
            r_spec_inv     <= 1'b0;
            r_spec_val     <= '0;
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a            <= rs1_data;
                r_b            <= {rs2_data[c_WORD_W-1] ^ op, rs2_data[c_WORD_W-2:0]};
                flag_invalid   <= 1'b0;
                flag_overflow  <= 1'b0;
                flag_underflow <= 1'b0;
            end
            case (r_state)
                S_ALIGN: begin
                    r_sign     <= w_big_sign;
                    r_eff_sub  <= (w_big_sign != w_sml_sign);
                    r_neg_zero <= w_zero_a & w_zero_b & r_a[c_WORD_W-1] & r_b[c_WORD_W-1];
                    r_exp      <= $signed({2'b00, w_big_exp});
                    r_sig_a    <= {w_big_sig, 3'b000};
                    r_sig_b    <= w_field_b;
                    r_spec     <= w_spec;
                    r_spec_inv <= w_spec_inv;
                    r_spec_val <= w_spec_val;
                end
                S_ADD: begin
                    r_sum <= r_eff_sub ? ({1'b0, r_sig_a} - {1'b0, r_sig_b})
                                       : ({1'b0, r_sig_a} + {1'b0, r_sig_b});
                end
                S_NORM: begin
                    r_is_zero <= (r_sum == '0);
                    if (r_sum[c_SUM_W-1]) begin
                        r_mant <= {r_sum[c_SUM_W-1:2], r_sum[1] | r_sum[0]};
                        r_exp  <= r_exp + 10'sd1;
                    end else begin
                        r_mant <= r_sum[c_FLD_W-1:0] << w_lzc;
                        r_exp  <= r_exp - $signed({5'd0, w_lzc});
                    end
                end
                S_ROUND: begin
                    // Results become visible on the edge that enters DONE.
                    if (r_spec) begin
                        result         <= r_spec_val;
                        flag_invalid   <= r_spec_inv;
                        flag_overflow  <= 1'b0;
                        flag_underflow <= 1'b0;
                    end else begin
                        result         <= w_final;
                        flag_invalid   <= 1'b0;
                        flag_overflow  <= w_ovf;
                        flag_underflow <= w_unf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_unit
// Purpose  : Scoreboard bench for fp_add_unit. Stimulus pushes expected
//            results; a negedge monitor pops and compares on every done.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;

    fp_add_unit dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        inv;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: actual=done required=no_done");
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.name, {29'd0, result, flag_invalid, flag_overflow, flag_underflow},
                      {29'd0, mon_e.res, mon_e.inv, mon_e.ovf, mon_e.unf});
            end
        end
    end

    task automatic push(input string name, input logic [31:0] r,
                        input logic inv, input logic ovf, input logic unf);
        exp_t e;
        e.name = name; e.res = r; e.inv = inv; e.ovf = ovf; e.unf = unf;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clock);
    endtask

    // One operation; called at a negedge, returns at the negedge after done.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] r,
                          input logic inv, input logic ovf, input logic unf);
        bit seen;
        wait_idle();
        rs1_data = a; rs2_data = b; op = o; start = 1'b1;
        push(name, r, inv, ovf, unf);
        @(negedge clock);
        start = 1'b0;
        check({name, "_busy"}, {63'd0, busy}, 64'd1);
        seen = 1'b0;
        for (int k = 2; k <= 12 && !seen; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1;
                check({name, "_latency"}, 64'(k), 64'd5);
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: actual=no_done required=done", name);
        end
    endtask

    int hits[3];
    int nhit;
    int d0;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {57'd0, busy, done, flag_invalid, flag_overflow, flag_underflow, 2'b00}, 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed arithmetic vectors
        run_op("add_same_sign",  32'hBE800000, 32'hBE700000, 1'b0, 32'hBEF80000, 0, 0, 0);
        run_op("sub_lshift4",    32'hBE800000, 32'hBE700000, 1'b1, 32'hBC800000, 0, 0, 0);
        run_op("cancel_zero",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 0, 0, 0);
        run_op("rne_tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 0, 0, 0);
        run_op("rne_tie_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 0, 0, 0);
        run_op("inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1, 0, 0);
        run_op("inf_sub_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1, 0, 0);
        run_op("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 0, 1, 0);
        run_op("flush_input",    32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 0, 0, 0);
        run_op("underflow",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 0, 0, 1);
        run_op("nan_input",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1, 0, 0);
        run_op("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 0, 0, 0);
        run_op("neginf_sub_inf", 32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 0, 0, 0);
        run_op("neg_zero_sum",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 0, 0, 0);

        // Start pulsed at E2 must be ignored
        wait_idle();
        d0 = n_done;
        rs1_data = 32'h3F800000; rs2_data = 32'h3F800000; op = 1'b0; start = 1'b1;
        push("ignore_first", 32'h40000000, 0, 0, 0);
        @(negedge clock); start = 1'b0;
        @(negedge clock); rs1_data = 32'h40400000; rs2_data = 32'h7F800000; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (10) @(negedge clock);
        check("ignored_start_dones", 64'(n_done - d0), 64'd1);

        // Start held high: restarts at every E5
        wait_idle();
        nhit = 0;
        rs1_data = 32'h40000000; rs2_data = 32'h40000000; op = 1'b0; start = 1'b1;
        push("held_x1", 32'h40800000, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (done === 1'b1 && nhit < 3) begin
                hits[nhit] = c;
                nhit++;
                if (nhit == 1) begin
                    rs1_data = 32'h40400000; rs2_data = 32'h3F800000; op = 1'b1;
                    push("held_x2", 32'h40000000, 0, 0, 0);
                end else if (nhit == 2) begin
                    rs1_data = 32'h3FC00000; rs2_data = 32'h3FC00000; op = 1'b0;
                    push("held_x3", 32'h40400000, 0, 0, 0);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_done_count", 64'(nhit), 64'd3);
        check("held_done_e4",  64'(hits[0]), 64'd5);
        check("held_done_e9",  64'(hits[1]), 64'd10);
        check("held_done_e14", 64'(hits[2]), 64'd15);

        // Asynchronous reset between E2 and E3 aborts the operation
        wait_idle();
        rs1_data = 32'h3F800000; rs2_data = 32'h40000000; op = 1'b0; start = 1'b1;
        push("aborted", 32'h40400000, 0, 0, 0);
        @(posedge clock);            // E0
        start = 1'b0;
        @(posedge clock);            // E1
        @(posedge clock);            // E2
        #2 reset = 1'b1;
        #1;
        check("abort_outputs", {59'd0, busy, done, flag_invalid, flag_overflow, flag_underflow}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        d0 = n_done;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        check("abort_pending", 64'(sb_q.size()), 64'd1);
        sb_q.delete();
        check("abort_result_held", {32'd0, result}, 64'd0);

        run_op("after_reset", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
